// File: rtl/latch_tester_pkg.sv
// Shared types and the fixed stimulus table for the latch tester.
// The table lists the (rst, en, d) vectors applied to the latch under test, in order.
package latch_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic rst;
        logic en;
        logic d;
    } vec_t;

    localparam int         N_VEC    = 8;
    localparam int         IDX_W    = 3;
    localparam int         ERR_W    = 4;
    localparam logic [2:0] IDX_LAST = 3'd7;
    localparam logic [3:0] ERR_MAX  = 4'd15;

    localparam vec_t VEC_TABLE [N_VEC] = '{
        '{rst: 1'b0, en: 1'b1, d: 1'b1},
        '{rst: 1'b0, en: 1'b1, d: 1'b0},
        '{rst: 1'b0, en: 1'b0, d: 1'b1},
        '{rst: 1'b1, en: 1'b0, d: 1'b0},
        '{rst: 1'b0, en: 1'b1, d: 1'b1},
        '{rst: 1'b0, en: 1'b0, d: 1'b0},
        '{rst: 1'b1, en: 1'b1, d: 1'b1},
        '{rst: 1'b0, en: 1'b1, d: 1'b1}
    };

    function automatic vec_t vec_at(input logic [IDX_W-1:0] idx);
        return VEC_TABLE[idx];
    endfunction

endpackage

// File: rtl/latch_tester_ref_model.sv
// Golden model of the latch under test: tracks the Q value a correct latch
// should hold after each applied vector (reset dominates enable).
module latch_ref_model
    import latch_tester_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_init,
    input  logic i_update,
    input  vec_t i_vec,
    output logic o_exp
);

    logic r_exp;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp <= 1'b0;
        end else if (i_init) begin
            r_exp <= 1'b0;
        end else if (i_update) begin
            if (i_vec.rst) begin
                r_exp <= 1'b0;
            end else if (i_vec.en) begin
                r_exp <= i_vec.d;
            end
        end
    end

    assign o_exp = r_exp;

endmodule

// File: rtl/latch_tester.sv
// Sequences the fixed vector table onto a latch under test, waits SETTLE cycles
// per vector, and compares Q/QN against the golden model, reporting a verdict.
module latch_tester
    import latch_tester_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             d_o,
    output logic             en_o,
    output logic             rst_o,
    input  logic             q_i,
    input  logic             qn_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_idx
);

    localparam logic [3:0] WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_wait_cnt;
    logic [ERR_W-1:0] r_err_count;
    logic [IDX_W-1:0] r_fail_idx;
    logic             r_pass;
    logic             r_d;
    logic             r_en;
    logic             r_rst;

    vec_t             w_vec;
    logic             w_exp;
    logic             w_fail;
    logic             w_start_ok;

    assign w_vec      = vec_at(r_idx);
    assign w_fail     = (q_i != w_exp) || (qn_i != ~w_exp);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    latch_ref_model u_ref_model (
        .clk      (clk),
        .reset    (reset),
        .i_init   (r_state == ST_INIT),
        .i_update (r_state == ST_DRIVE),
        .i_vec    (w_vec),
        .o_exp    (w_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                w_next_state = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_next_state = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_next_state = (r_idx == IDX_LAST) ? ST_DONE : ST_DRIVE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Drive pins are only written on start and in DRIVE, so they hold elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
            r_pass      <= 1'b0;
            r_d         <= 1'b0;
            r_en        <= 1'b0;
            r_rst       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_idx       <= '0;
                        r_err_count <= '0;
                        r_fail_idx  <= '0;
                        r_pass      <= 1'b0;
                        r_rst       <= 1'b1;
                        r_en        <= 1'b0;
                        r_d         <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_rst      <= w_vec.rst;
                    r_en       <= w_vec.en;
                    r_d        <= w_vec.d;
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (w_fail) begin
                        if (r_err_count != ERR_MAX) begin
                            r_err_count <= r_err_count + 4'd1;
                        end
                        if (r_err_count == '0) begin
                            r_fail_idx <= r_idx;
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        r_pass <= (r_err_count == '0) && !w_fail;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_INIT) || (r_state == ST_DRIVE) ||
                       (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_idx  = r_fail_idx;
    assign d_o       = r_d;
    assign en_o      = r_en;
    assign rst_o     = r_rst;

endmodule

// File: tb/tb_latch_tester.sv
// Bench for latch_tester: a behavioural latch with selectable faults feeds the
// tester; expected verdicts come from walking the vector table arithmetically.
module tb_latch_tester;

    localparam int S       = 2;
    localparam int RUN_LEN = 1 + 8 * (S + 2);
    localparam int RUN_Z   = 1 + 8 * 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       d_o, en_o, rst_o, q_i, qn_i, busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] fail_idx;

    logic       start_z = 1'b0;
    logic       d_z, en_z, rst_z, busy_z, done_z, pass_z;
    logic [3:0] err_z;
    logic [2:0] fail_z;

    logic [7:0] rst_tab = 8'b0100_1000;
    logic [7:0] en_tab  = 8'b1101_0011;
    logic [7:0] d_tab   = 8'b1101_0101;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         mode = 0;
    logic [7:0] mask_q = '0;
    logic [7:0] mask_qn = '0;
    logic       lq = 1'b0;
    logic       lq_z = 1'b0;
    logic       fq, fqn;
    int         rel_c, kk;

    latch_tester #(.SETTLE(S)) dut (
        .clk(clk), .reset(reset), .start(start),
        .d_o(d_o), .en_o(en_o), .rst_o(rst_o),
        .q_i(q_i), .qn_i(qn_i),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx)
    );

    latch_tester #(.SETTLE(0)) dut_z (
        .clk(clk), .reset(reset), .start(start_z),
        .d_o(d_z), .en_o(en_z), .rst_o(rst_z),
        .q_i(lq_z), .qn_i(~lq_z),
        .busy(busy_z), .done(done_z), .pass(pass_z),
        .err_count(err_z), .fail_idx(fail_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural latches settle half a cycle after the tester's drive edge.
    always @(negedge clk) begin
        if (rst_o) lq <= 1'b0;
        else if (en_o) lq <= d_o;
        if (rst_z) lq_z <= 1'b0;
        else if (en_z) lq_z <= d_z;
    end

    always_comb begin
        rel_c = cyc - t0;
        kk    = (rel_c - 2) / (S + 2);
        fq    = 1'b0;
        fqn   = 1'b0;
        if (mode == 3 && rel_c >= 2 && kk < 8) begin
            fq  = mask_q[kk[2:0]];
            fqn = mask_qn[kk[2:0]];
        end
        case (mode)
            1:       begin q_i = 1'b0; qn_i = 1'b1; end
            2:       begin q_i = lq;   qn_i = lq;   end
            default: begin q_i = lq ^ fq; qn_i = ~lq ^ fqn; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk the table: a good latch ends each vector at rst ? 0 : en ? d : previous.
    task automatic ref_run(input int m, input logic [7:0] mq, input logic [7:0] mqn,
                           output int e_err, output int e_first);
        logic q_good;
        bit   found, f;
        q_good = 1'b0;
        e_err = 0;
        e_first = 0;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            if (rst_tab[k]) q_good = 1'b0;
            else if (en_tab[k]) q_good = d_tab[k];
            case (m)
                1:       f = (q_good != 1'b0);
                2:       f = 1;
                3:       f = mq[k] | mqn[k];
                default: f = 0;
            endcase
            if (f) begin
                if (!found) e_first = k;
                found = 1;
                e_err = (e_err < 15) ? e_err + 1 : 15;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk) start = 1'b0;
        check("busy_in_init", busy, 1);
        check("init_drive", {rst_o, en_o, d_o}, 3'b100);
    endtask

    task automatic run_seq(input int m, input bit extra);
        int e_err, e_first, rel, extra_at, k;
        bit seen;
        mode = m;
        if (m == 3) begin
            mask_q  = 8'($urandom) & 8'($urandom);
            mask_qn = 8'($urandom) & 8'($urandom);
        end
        ref_run(m, mask_q, mask_qn, e_err, e_first);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_start();
        extra_at = extra ? int'($urandom_range(3, 30)) : -1;
        seen = 0;
        rel = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            rel = cyc - t0;
            start = (rel == extra_at);
            k = rel / (S + 2) - 1;
            if (rel % (S + 2) == 0 && k >= 0 && k < 8)
                check("vec_drive", {rst_o, en_o, d_o}, {rst_tab[k], en_tab[k], d_tab[k]});
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("done_latency", rel, RUN_LEN);
        check("pass", pass, (e_err == 0));
        check("err_count", err_count, e_err);
        check("fail_idx", fail_idx, e_first);
        check("busy_in_done", busy, 0);
        repeat (2) @(negedge clk);
        check("done_hold", {done, pass, err_count, fail_idx}, {1'b1, 1'(e_err == 0), 4'(e_err), 3'(e_first)});
    endtask

    task automatic reset_mid_run();
        int rel;
        mode = 1;
        pulse_start();
        rel = 0;
        for (int n = 0; n < 100 && rel != 14; n++) begin
            @(negedge clk);
            rel = cyc - t0;
        end
        check("reached_wait3", rel, 14);
        check("err_before_reset", err_count, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_clear",
              {busy, done, pass, err_count, fail_idx, d_o, en_o, rst_o}, 14'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done}, 2'b00);
    endtask

    task automatic run_fast();
        int rel;
        bit seen;
        @(negedge clk) start_z = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk) start_z = 1'b0;
        seen = 0;
        rel = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (done_z) seen = 1;
        end
        check("z_done_latency", rel, RUN_Z);
        check("z_verdict", {pass_z, err_z, fail_z}, 8'h80);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("reset_state",
              {busy, done, pass, err_count, fail_idx, d_o, en_o, rst_o}, 14'h0);
        check("reset_state_z", {busy_z, done_z, pass_z, err_z, fail_z}, 10'h0);
        run_seq(0, 0);
        run_seq(1, 0);
        run_seq(2, 0);
        run_seq(0, 1);
        reset_mid_run();
        run_seq(0, 0);
        for (int i = 0; i < 6; i++) run_seq(3, 1'($urandom_range(0, 1)));
        run_fast();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/latch_tester.md
LATCH_TESTER -- requirements
Module: latch_tester

Interface
REQ-001 Parameter SETTLE, default 2: cycles waited after driving a vector before sampling the latch outputs (legal 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run the full vector sequence.
REQ-005 d_o  output  1  data driven to the latch under test.
REQ-006 en_o  output  1  enable driven to the latch under test.
REQ-007 rst_o  output  1  reset driven to the latch under test.
REQ-008 q_i  input  1  latch Q output.
REQ-009 qn_i  input  1  latch complementary output.
REQ-010 busy  output  1  high from INIT through CHECK of the last vector.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  valid when done; 1 iff err_count==0.
REQ-013 err_count  output  4  number of failing vectors, saturating at 15.
REQ-014 fail_idx  output  3  index of first failing vector; 0 if none.

Function
REQ-015 The FSM SHALL use states IDLE, INIT, DRIVE, WAIT, CHECK, DONE.
REQ-016 The fixed 8-entry table SHALL be (rst,en,d): 0:(0,1,1) 1:(0,1,0) 2:(0,0,1) 3:(1,0,0) 4:(0,1,1) 5:(0,0,0) 6:(1,1,1) 7:(0,1,1).
REQ-017 IDLE or DONE with start=1 SHALL go to INIT and clear err_count, fail_idx, pass, and vector index.
REQ-018 INIT SHALL last one cycle driving rst_o=1, en_o=0, d_o=0 and set the reference model to 0; then go to DRIVE.
REQ-019 DRIVE SHALL register the current table entry onto rst_o/en_o/d_o and update the model: exp = rst ? 0 : en ? d : exp (reset has priority over enable).
REQ-020 WAIT SHALL last exactly SETTLE cycles (zero cycles when SETTLE=0, going straight to CHECK).
REQ-021 CHECK SHALL flag a failure when q_i!=exp or qn_i!=~exp; on failure err_count increments (saturating) and fail_idx is captured only on the first failure.
REQ-022 From CHECK: index 7 -> DONE; otherwise index+1 -> DRIVE.
REQ-023 Driven outputs SHALL hold their last values during WAIT, CHECK, and DONE.
REQ-024 done SHALL assert exactly 1+8*(SETTLE+2) cycles after the edge that samples start (33 for SETTLE=2).
REQ-025 start while busy SHALL be ignored.
REQ-026 DONE SHALL hold err_count, fail_idx, and pass until a new start or reset.

Reset
REQ-027 On reset the FSM SHALL go to IDLE regardless of state, including mid-sequence.
REQ-028 Reset SHALL clear busy, done, pass, err_count, fail_idx, d_o, en_o, rst_o, the model, and the index to 0.

Structure
REQ-029 Package latch_tester_pkg SHALL hold the state enum, the vector struct {rst,en,d}, and the 8-entry table constant.
REQ-030 Sub-module latch_ref_model SHALL implement the golden latch model (init, update, exp output).

Verification
REQ-031 Correct behavioural DLatch connected, start pulse -> done at cycle 33, pass=1, err_count=0, fail_idx=0.
REQ-032 Latch replaced by q_i=0, qn_i=1 constant -> vectors 0,4,5,7 fail; err_count=4, fail_idx=0, pass=0.
REQ-033 Correct latch but qn_i tied to q_i -> every vector fails; err_count=8, pass=0.
REQ-034 Reset asserted during WAIT of vector 3 -> next cycle IDLE, all outputs 0; a later start completes with pass=1.
REQ-035 Second start pulse while busy -> no restart; done still at cycle 33.
REQ-036 SETTLE=0 build with correct latch -> done at cycle 17, pass=1.
